fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and decode. Captures each {PC, instruction} pair produced by fetch plus instruction memory, buffers up to DEPTH of them, and presents them to decode in order through a valid/ready handshake. A flush input discards all buffered entries on a taken branch, so decode never sees wrong-path instructions.

## Interface
- N, 64, PC width
- W, 32, instruction width
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- flush_F  input  1  discard all entries; asserted with the taken-branch PCSrc_F
- enq_valid_F  input  1  fetch presents a pair
- enq_ready_F  output  1  queue can accept (not full)
- enq_pc_F  input  N  PC of the instruction (imem_addr_F)
- enq_instr_F  input  W  instruction word from instruction memory
- deq_valid_D  output  1  head entry is valid
- deq_ready_D  input  1  decode consumes the head
- deq_pc_D  output  N  PC of the head entry
- deq_instr_D  output  W  instruction of the head entry
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: a DEPTH-entry circular buffer of {pc, instr}, a write pointer, a read pointer (each $clog2(DEPTH) bits), and an occupancy counter.
- Pointers wrap from DEPTH-1 to 0 by natural overflow.
- Enqueue fires when enq_valid_F && enq_ready_F && !flush_F. It writes the pair at the write pointer and increments the write pointer.
- Dequeue fires when deq_valid_D && deq_ready_D. It increments the read pointer.
- enq_ready_F = (count != DEPTH). The queue gives no pass-through when full: an enqueue is refused when full even if a dequeue fires in the same cycle.
- deq_valid_D = (count != 0) && !flush_F.
- deq_pc_D and deq_instr_D show the head entry combinationally (first-word fall-through). They are driven to 0 whenever deq_valid_D is 0.
- count update per cycle:
  - +1 on enqueue only
  - -1 on dequeue only
  - unchanged when both or neither fire
- flush_F has priority over everything else. On the next edge, count and both pointers go to 0, and any enqueue attempted in the flush cycle is dropped. Because deq_valid_D is low during flush, no dequeue fires in that cycle.
- Reset (reset = 0) asynchronously clears count, both pointers and the storage array to 0. All outputs go to their reset values immediately, without waiting for a clock edge:
  - enq_ready_F = 1
  - deq_valid_D = 0
  - deq_pc_D = 0, deq_instr_D = 0
  - count = 0
- An assertion of reset mid-operation loses all entries. No partial state survives.

## Timing
- All state updates on the rising edge of clk.
- Enqueue-to-dequeue latency is 1 cycle: a pair accepted at edge t is visible on deq_* after edge t and can be consumed at edge t+1.
- Back-to-back throughput is 1 pair per cycle when fetch and decode both stream.
- enq_ready_F depends only on registered count. It has no combinational path from deq_ready_D.
- deq_valid_D has a combinational path from flush_F only.
- The first edge after reset deassertion may already enqueue.

## Structure
- A shared package fetch_pkg holds:
  - the INSTR_W = 32 constant
  - a packed struct fq_entry_t {logic [N-1:0] pc; logic [W-1:0] instr;} parameterised through localparams
  - the DEPTH legality check, as an elaboration-time assertion
- One sub-module, fq_regfile: DEPTH x (N+W) register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset of its own other than the asynchronous clear.
- The top level holds the pointers, count, handshake logic and flush priority.

## Test plan
- Reset then idle: hold reset low for 2 cycles, then release.
  - enq_ready_F = 1, deq_valid_D = 0, count = 0, deq_pc_D = 0.
- Single pass: enqueue pc = 0x0, instr = 0x8B020020 with deq_ready_D = 1.
  - The next cycle shows deq_valid_D = 1 with the same pair; count goes 1 then 0.
- Fill and stall: deq_ready_D = 0; enqueue pc = 0x0, 0x4, 0x8, 0xC, 0x10.
  - count = 4 and enq_ready_F = 0 after the fourth enqueue; pc 0x10 is refused.
  - Then draining yields 0x0, 0x4, 0x8, 0xC in order.
- Wrap-around: stream 10 sequential pcs (0x0 to 0x24) while deq_ready_D toggles 1,0,1,0.
  - All 10 come out in order with no duplicates; the pointers wrap at least twice.
- Flush with simultaneous enqueue: hold 3 entries, then assert flush_F together with an enqueue of pc = 0x40.
  - During that cycle deq_valid_D = 0; the next cycle count = 0.
  - A following enqueue of pc = 0x80 is the next dequeued entry.
- Mid-operation reset: with 2 entries held, pull reset low between edges.
  - deq_valid_D falls and count = 0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: definitions shared by the fetch queue, its storage and its users.
//   PC_W / INSTR_W : default PC and instruction widths
//   fq_entry_t     : one buffered {pc, instr} pair
//   depth_legal()  : DEPTH must be a power of two and at least 2
package fetch_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic bit depth_legal(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side enqueue and decode-side dequeue handshake.
//   slave  : the queue (takes enq_* / deq_ready_D / flush_F, drives the rest)
//   master : the environment (fetch + decode)
interface fetch_queue_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          flush_F;
    logic          enq_valid_F;
    logic          enq_ready_F;
    logic [N-1:0]  enq_pc_F;
    logic [W-1:0]  enq_instr_F;
    logic          deq_valid_D;
    logic          deq_ready_D;
    logic [N-1:0]  deq_pc_D;
    logic [W-1:0]  deq_instr_D;
    logic [CW-1:0] count;

    modport master (
        output flush_F, enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D,
        input  enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D, count
    );

    modport slave (
        input  flush_F, enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D,
        output enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D, count
    );

endinterface

// File: rtl/fq_regfile.sv
// fq_regfile: DEPTH x DATA_W register array, one write port, one
// asynchronous read port. Contents clear asynchronously with reset.
//   clk, reset (active-low, async)
//   we, waddr, wdata : write port, rising edge
//   raddr, rdata     : combinational read port
module fq_regfile #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr} buffer between fetch and decode.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   fq    : fetch_queue_if.slave -- enq_* from fetch, deq_* to decode,
//           flush_F discards all entries, count = occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned N     = PC_W,
    parameter int unsigned W     = INSTR_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (!depth_legal(DEPTH)) begin : g_depth_check
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic           enq_fire;
    logic           deq_fire;
    logic           not_empty;
    logic [N+W-1:0] head;

    // enq_ready depends only on registered count, never on deq_ready_D.
    assign fq.enq_ready_F = (count_q != FULL);
    assign not_empty      = (count_q != '0);
    assign fq.deq_valid_D = not_empty && !fq.flush_F;
    assign fq.count       = count_q;

    assign enq_fire = fq.enq_valid_F && fq.enq_ready_F && !fq.flush_F;
    assign deq_fire = fq.deq_valid_D && fq.deq_ready_D;

    fq_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (N + W),
        .AW     (AW)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (enq_fire),
        .waddr (wr_ptr),
        .wdata ({fq.enq_pc_F, fq.enq_instr_F}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head shown combinationally; forced to zero whenever not valid.
    always_comb begin
        fq.deq_pc_D    = '0;
        fq.deq_instr_D = '0;
        if (fq.deq_valid_D) begin
            fq.deq_pc_D    = head[N+W-1:W];
            fq.deq_instr_D = head[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (fq.flush_F) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            if (enq_fire && !deq_fire)      count_q <= count_q + 1'b1;
            else if (deq_fire && !enq_fire) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fq_entry_t q[$];
    logic [63:0] drained[$];

    fetch_queue_if #(.N(64), .W(32), .DEPTH(DEPTH)) fq ();

    fetch_queue #(.N(64), .W(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq.slave)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the reference queue, then advance one edge.
    task automatic cycle(input bit flush, input bit ev, input logic [63:0] pc,
                         input logic [31:0] ins, input bit dr, output bit accepted);
        bit exp_valid, exp_ready, deq_f;
        fq.flush_F     = flush;
        fq.enq_valid_F = ev;
        fq.enq_pc_F    = pc;
        fq.enq_instr_F = ins;
        fq.deq_ready_D = dr;
        #1;
        exp_valid = (q.size() != 0) && !flush;
        exp_ready = (q.size() != DEPTH);
        check("count", 64'(fq.count), 64'(q.size()));
        check("enq_ready", 64'(fq.enq_ready_F), 64'(exp_ready));
        check("deq_valid", 64'(fq.deq_valid_D), 64'(exp_valid));
        check("deq_pc", fq.deq_pc_D, exp_valid ? q[0].pc : 64'h0);
        check("deq_instr", 64'(fq.deq_instr_D), exp_valid ? 64'(q[0].instr) : 64'h0);
        accepted = ev && exp_ready && !flush;
        deq_f    = exp_valid && dr;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (deq_f) drained.push_back(q.pop_front().pc);
            if (accepted) q.push_back('{pc: pc, instr: ins});
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int sent;
        int k;
        logic [63:0] exp_pcs[$];

        checks = 0;
        errors = 0;
        reset = 0;
        fq.flush_F = 0; fq.enq_valid_F = 0; fq.enq_pc_F = '0;
        fq.enq_instr_F = '0; fq.deq_ready_D = 0;
        repeat (2) @(negedge clk);
        check("rst_enq_ready", 64'(fq.enq_ready_F), 64'h1);
        check("rst_deq_valid", 64'(fq.deq_valid_D), 64'h0);
        check("rst_count", 64'(fq.count), 64'h0);
        check("rst_deq_pc", fq.deq_pc_D, 64'h0);
        reset = 1;

        // Single pass
        cycle(0, 1, 64'h0, 32'h8B020020, 1, acc);
        cycle(0, 0, 64'h0, 32'h0, 1, acc);
        cycle(0, 0, 64'h0, 32'h0, 1, acc);
        check("single_drained", drained.size() == 1 ? drained[0] : 64'hdead, 64'h0);

        // Fill and stall, then drain
        drained.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 64'(i * 4), $urandom, 0, acc);
            check("fill_accept", 64'(acc), 64'(i < 4));
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 64'h0, 32'h0, 1, acc);
        check("fill_drain_n", 64'(drained.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("fill_order", i < drained.size() ? drained[i] : 64'hdead, 64'(i * 4));

        // Wrap-around stream with toggling deq_ready
        drained.delete();
        sent = 0;
        k = 0;
        while (drained.size() < 10 && k < 100) begin
            cycle(0, sent < 10, 64'(sent * 4), $urandom, (k % 2) == 0, acc);
            if (acc) sent++;
            k++;
        end
        check("wrap_n", 64'(drained.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            check("wrap_order", i < drained.size() ? drained[i] : 64'hdead, 64'(i * 4));

        // Flush with simultaneous enqueue
        drained.delete();
        for (int i = 0; i < 3; i++) cycle(0, 1, 64'(100 + i), $urandom, 0, acc);
        cycle(1, 1, 64'h40, 32'h1234, 1, acc);
        check("flush_count", 64'(fq.count), 64'h0);
        cycle(0, 1, 64'h80, 32'h5678, 0, acc);
        cycle(0, 0, 64'h0, 32'h0, 1, acc);
        check("flush_next", drained.size() == 1 ? drained[0] : 64'hdead, 64'h80);

        // Mid-operation reset between edges
        cycle(0, 1, 64'h200, $urandom, 0, acc);
        cycle(0, 1, 64'h204, $urandom, 0, acc);
        fq.enq_valid_F = 0;
        #2 reset = 0;
        #1;
        check("mrst_deq_valid", 64'(fq.deq_valid_D), 64'h0);
        check("mrst_count", 64'(fq.count), 64'h0);
        check("mrst_enq_ready", 64'(fq.enq_ready_F), 64'h1);
        check("mrst_deq_pc", fq.deq_pc_D, 64'h0);
        q.delete();
        @(negedge clk);
        reset = 1;
        cycle(0, 1, 64'h300, 32'hCAFE, 0, acc);
        check("post_rst_accept", 64'(acc), 64'h1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 16) == 0, $urandom % 2, {$urandom, $urandom}, $urandom,
                  ($urandom % 3) != 0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
